// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse timing thresholds, ASCII constants and FSM states
// MORSE_DIGITS_EN raises the symbol limit to 5 for digit patterns.
package morse_pkg;
   localparam logic [2:0] DOT_MAX    = 3'd2;
   localparam logic [2:0] LETTER_GAP = 3'd3;
   localparam logic [2:0] WORD_GAP   = 3'd7;
   // WORD is entered after LETTER_GAP units already elapsed
   localparam logic [2:0] WORD_UNITS = WORD_GAP - LETTER_GAP;

   localparam logic [7:0] SPACE = 8'h20;
   localparam logic [7:0] QMARK = 8'h3F;
   localparam logic [7:0] BLANK = 8'h00;

`ifdef MORSE_DIGITS_EN
   localparam logic [2:0] MAX_SYMBOLS = 3'd5;
`else
   localparam logic [2:0] MAX_SYMBOLS = 3'd4;
`endif

   typedef enum logic [1:0] {IDLE, PRESS, GAP, WORD} state_t;
endpackage

// File: rtl/morse_lut.sv
// rtl/morse_lut.sv - {count, pattern} to ASCII, first symbol in the MSB, 1 = dash
// Digit entries exist only with MORSE_DIGITS_EN defined.
module morse_lut (
   input  logic [2:0] count,
   input  logic [4:0] pattern,
   output logic [7:0] ascii
);
   import morse_pkg::*;

   always_comb begin
      ascii = QMARK;
      case ({count, pattern})
         {3'd2, 5'b00001}: ascii = 8'h41;
         {3'd4, 5'b01000}: ascii = 8'h42;
         {3'd4, 5'b01010}: ascii = 8'h43;
         {3'd3, 5'b00100}: ascii = 8'h44;
         {3'd1, 5'b00000}: ascii = 8'h45;
         {3'd4, 5'b00010}: ascii = 8'h46;
         {3'd3, 5'b00110}: ascii = 8'h47;
         {3'd4, 5'b00000}: ascii = 8'h48;
         {3'd2, 5'b00000}: ascii = 8'h49;
         {3'd4, 5'b00111}: ascii = 8'h4A;
         {3'd3, 5'b00101}: ascii = 8'h4B;
         {3'd4, 5'b00100}: ascii = 8'h4C;
         {3'd2, 5'b00011}: ascii = 8'h4D;
         {3'd2, 5'b00010}: ascii = 8'h4E;
         {3'd3, 5'b00111}: ascii = 8'h4F;
         {3'd4, 5'b00110}: ascii = 8'h50;
         {3'd4, 5'b01101}: ascii = 8'h51;
         {3'd3, 5'b00010}: ascii = 8'h52;
         {3'd3, 5'b00000}: ascii = 8'h53;
         {3'd1, 5'b00001}: ascii = 8'h54;
         {3'd3, 5'b00001}: ascii = 8'h55;
         {3'd4, 5'b00001}: ascii = 8'h56;
         {3'd3, 5'b00011}: ascii = 8'h57;
         {3'd4, 5'b01001}: ascii = 8'h58;
         {3'd4, 5'b01011}: ascii = 8'h59;
         {3'd4, 5'b01100}: ascii = 8'h5A;
`ifdef MORSE_DIGITS_EN
         {3'd5, 5'b11111}: ascii = 8'h30;
         {3'd5, 5'b01111}: ascii = 8'h31;
         {3'd5, 5'b00111}: ascii = 8'h32;
         {3'd5, 5'b00011}: ascii = 8'h33;
         {3'd5, 5'b00001}: ascii = 8'h34;
         {3'd5, 5'b00000}: ascii = 8'h35;
         {3'd5, 5'b10000}: ascii = 8'h36;
         {3'd5, 5'b11000}: ascii = 8'h37;
         {3'd5, 5'b11100}: ascii = 8'h38;
         {3'd5, 5'b11110}: ascii = 8'h39;
`endif
         default: ascii = QMARK;
      endcase
   end
endmodule

// File: rtl/morse_text_writer.sv
// rtl/morse_text_writer.sv - Morse key decoder feeding a 10-character scrolling text line
// MORSE_DIGITS_EN enables 5-symbol digit decoding.
module morse_text_writer #(
   parameter int UNIT_CYCLES = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   input  logic       clear,
   output logic [7:0] letter0,
   output logic [7:0] letter1,
   output logic [7:0] letter2,
   output logic [7:0] letter3,
   output logic [7:0] letter4,
   output logic [7:0] letter5,
   output logic [7:0] letter6,
   output logic [7:0] letter7,
   output logic [7:0] letter8,
   output logic [7:0] letter9,
   output logic [7:0] char_out,
   output logic       char_valid
);
   import morse_pkg::*;

   localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   logic          key_s1, key_s2;
   state_t        state;
   logic [PW-1:0] presc;
   logic [2:0]    units;
   logic [2:0]    sym_count;
   logic [4:0]    sym_pattern;
   logic          invalid;
   logic [7:0]    lut_char;
   logic          commit;
   logic [7:0]    commit_value;
   logic [7:0]    line [10];
   logic [3:0]    ptr;
   logic          tick;

   assign tick = (presc == PW'(UNIT_CYCLES - 1));

   morse_lut u_lut (
      .count   (sym_count),
      .pattern (sym_pattern),
      .ascii   (lut_char)
   );

   always_comb begin
      commit       = 1'b0;
      commit_value = lut_char;
      if (state == GAP && units == LETTER_GAP) begin
         commit       = 1'b1;
         commit_value = invalid ? QMARK : lut_char;
      end else if (state == WORD && units == WORD_UNITS) begin
         commit       = 1'b1;
         commit_value = SPACE;
      end
   end

   // Every state change restarts the prescaler and unit counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_s1      <= 1'b0;
         key_s2      <= 1'b0;
         state       <= IDLE;
         presc       <= '0;
         units       <= '0;
         sym_count   <= '0;
         sym_pattern <= '0;
         invalid     <= 1'b0;
      end else begin
         key_s1 <= key;
         key_s2 <= key_s1;
         presc  <= tick ? '0 : presc + 1'b1;
         if (tick && units != 3'd7)
            units <= units + 1'b1;

         if (clear) begin
            state       <= IDLE;
            presc       <= '0;
            units       <= '0;
            sym_count   <= '0;
            sym_pattern <= '0;
            invalid     <= 1'b0;
         end else begin
            case (state)
               IDLE: if (key_s2) begin
                  state <= PRESS;
                  presc <= '0;
                  units <= '0;
               end
               PRESS: if (!key_s2) begin
                  if (sym_count == MAX_SYMBOLS)
                     invalid <= 1'b1;
                  else begin
                     sym_count   <= sym_count + 1'b1;
                     sym_pattern <= {sym_pattern[3:0], units >= DOT_MAX};
                  end
                  state <= GAP;
                  presc <= '0;
                  units <= '0;
               end
               GAP: if (commit) begin
                  state       <= WORD;
                  presc       <= '0;
                  units       <= '0;
                  sym_count   <= '0;
                  sym_pattern <= '0;
                  invalid     <= 1'b0;
               end else if (key_s2) begin
                  state <= PRESS;
                  presc <= '0;
                  units <= '0;
               end
               WORD: if (commit) begin
                  state <= IDLE;
                  presc <= '0;
                  units <= '0;
               end else if (key_s2) begin
                  state <= PRESS;
                  presc <= '0;
                  units <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      char_valid <= 1'b0;
      if (reset) begin
         for (int i = 0; i < 10; i++) line[i] <= BLANK;
         ptr      <= '0;
         char_out <= BLANK;
      end else if (clear) begin
         for (int i = 0; i < 10; i++) line[i] <= BLANK;
         ptr <= '0;
      end else if (commit) begin
         char_out   <= commit_value;
         char_valid <= 1'b1;
         if (ptr < 4'd10) begin
            line[ptr] <= commit_value;
            ptr       <= ptr + 1'b1;
         end else begin
            for (int i = 0; i < 9; i++) line[i] <= line[i+1];
            line[9] <= commit_value;
         end
      end
   end

   assign letter0 = line[0];
   assign letter1 = line[1];
   assign letter2 = line[2];
   assign letter3 = line[3];
   assign letter4 = line[4];
   assign letter5 = line[5];
   assign letter6 = line[6];
   assign letter7 = line[7];
   assign letter8 = line[8];
   assign letter9 = line[9];
endmodule

// File: tb/tb_morse_text_writer.sv
// tb/tb_morse_text_writer.sv - self-checking bench for morse_text_writer
// Digit expectations follow MORSE_DIGITS_EN.
module tb_morse_text_writer;
   localparam int U = 4;

   logic       clk = 1'b0;
   logic       reset, key, clear;
   logic [7:0] letter0, letter1, letter2, letter3, letter4;
   logic [7:0] letter5, letter6, letter7, letter8, letter9;
   logic [7:0] char_out;
   logic       char_valid;
   logic [7:0] ltr [10];

   int         checks = 0;
   int         passed = 0;
   int         pulses = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mon_exp;

   always #5 clk = ~clk;

   morse_text_writer #(.UNIT_CYCLES(U)) dut (
      .clk(clk), .reset(reset), .key(key), .clear(clear),
      .letter0(letter0), .letter1(letter1), .letter2(letter2), .letter3(letter3),
      .letter4(letter4), .letter5(letter5), .letter6(letter6), .letter7(letter7),
      .letter8(letter8), .letter9(letter9),
      .char_out(char_out), .char_valid(char_valid)
   );

   assign ltr[0] = letter0; assign ltr[1] = letter1; assign ltr[2] = letter2;
   assign ltr[3] = letter3; assign ltr[4] = letter4; assign ltr[5] = letter5;
   assign ltr[6] = letter6; assign ltr[7] = letter7; assign ltr[8] = letter8;
   assign ltr[9] = letter9;

   typedef struct {
      int         n;
      logic [4:0] pat;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [10];
   vec_t alpha [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: every char_valid pulse pops one expected character.
   always @(negedge clk) begin
      if (char_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pulse: char_out %0h with nothing expected", char_out);
         end else begin
            mon_exp = exp_q.pop_front();
            check("char_out", {24'd0, char_out}, {24'd0, mon_exp});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; key = 1'b0; clear = 1'b0;
      step(3);
      reset = 1'b0;
      exp_q.delete();
      pulses = 0;
   endtask

   task automatic send_letter(input int n, input logic [4:0] pat);
      for (int i = n - 1; i >= 0; i--) begin
         key = 1'b1;
         step(pat[i] ? 3 * U : U);
         key = 1'b0;
         step(U);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      vecs[0] = '{1, 5'b00000, 8'h45};
      vecs[1] = '{1, 5'b00001, 8'h54};
      vecs[2] = '{2, 5'b00001, 8'h41};
      vecs[3] = '{4, 5'b01010, 8'h43};
      vecs[4] = '{3, 5'b00000, 8'h53};
      vecs[5] = '{4, 5'b01101, 8'h51};
      vecs[6] = '{4, 5'b01100, 8'h5A};
      vecs[7] = '{4, 5'b00011, 8'h3F};
`ifdef MORSE_DIGITS_EN
      vecs[8] = '{5, 5'b11111, 8'h30};
      vecs[9] = '{5, 5'b00000, 8'h35};
`else
      vecs[8] = '{5, 5'b11111, 8'h3F};
      vecs[9] = '{5, 5'b00000, 8'h3F};
`endif
      alpha[0]  = '{2, 5'b00001, 8'h41};
      alpha[1]  = '{4, 5'b01000, 8'h42};
      alpha[2]  = '{4, 5'b01010, 8'h43};
      alpha[3]  = '{3, 5'b00100, 8'h44};
      alpha[4]  = '{1, 5'b00000, 8'h45};
      alpha[5]  = '{4, 5'b00010, 8'h46};
      alpha[6]  = '{3, 5'b00110, 8'h47};
      alpha[7]  = '{4, 5'b00000, 8'h48};
      alpha[8]  = '{2, 5'b00000, 8'h49};
      alpha[9]  = '{4, 5'b00111, 8'h4A};
      alpha[10] = '{3, 5'b00101, 8'h4B};

      do_reset();
      for (int i = 0; i < 10; i++) check($sformatf("reset_letter%0d", i), ltr[i], 0);
      check("reset_char_out", char_out, 0);
      check("reset_char_valid", char_valid, 0);

      for (int v = 0; v < 10; v++) begin
         do_reset();
         exp_q.push_back(vecs[v].exp);
         send_letter(vecs[v].n, vecs[v].pat);
         step(16);
         check($sformatf("vec%0d_letter0", v), letter0, vecs[v].exp);
         check($sformatf("vec%0d_letter1", v), letter1, 0);
         check($sformatf("vec%0d_pulses", v), pulses, 1);
      end

      // C followed by E lands in the next slot
      do_reset();
      exp_q.push_back(8'h43); exp_q.push_back(8'h45);
      send_letter(4, 5'b01010); step(16);
      send_letter(1, 5'b00000); step(16);
      drain("ce_drain");
      check("ce_letter0", letter0, 8'h43);
      check("ce_letter1", letter1, 8'h45);

      // A..K overflows the line by one and scrolls left
      do_reset();
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back(alpha[i].exp);
         send_letter(alpha[i].n, alpha[i].pat);
         step(16);
      end
      drain("scroll_drain");
      for (int i = 0; i < 10; i++) check($sformatf("scroll_letter%0d", i), ltr[i], alpha[i+1].exp);
      check("scroll_pulses", pulses, 11);

      // T then long silence: letter plus a single word space
      do_reset();
      exp_q.push_back(8'h54); exp_q.push_back(8'h20);
      send_letter(1, 5'b00001);
      step(20 * U);
      drain("word_drain");
      check("word_letter0", letter0, 8'h54);
      check("word_letter1", letter1, 8'h20);
      check("word_letter2", letter2, 8'h00);
      check("word_pulses", pulses, 2);

      // very long press saturates and stays a dash
      do_reset();
      exp_q.push_back(8'h54);
      key = 1'b1; step(40 * U);
      key = 1'b0; step(20);
      drain("long_drain");
      check("long_letter0", letter0, 8'h54);

      // clear mid-press drops the partial symbol and the line
      do_reset();
      exp_q.push_back(8'h45);
      send_letter(1, 5'b00000); step(16);
      check("clr_pre_letter0", letter0, 8'h45);
      key = 1'b1; step(6);
      clear = 1'b1; key = 1'b0; step(4);
      clear = 1'b0; step(60);
      for (int i = 0; i < 10; i++) check($sformatf("clr_letter%0d", i), ltr[i], 0);
      check("clr_pulses", pulses, 1);
      exp_q.push_back(8'h45);
      send_letter(1, 5'b00000); step(16);
      drain("clr_drain");
      check("clr_post_letter0", letter0, 8'h45);
      check("clr_post_letter1", letter1, 8'h00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
